// File: rtl/scoreboard_pkg.sv
// Shared constants and types for the scoreboard blocks.
//   BCD_DIGIT_MAX : largest value a BCD digit may hold
//   BCD_W         : bits per BCD digit
//   NDIG_DEFAULT  : default number of score digits
//   score_op_e    : operation applied to the score in one cycle
package scoreboard_pkg;

  localparam int unsigned BCD_DIGIT_MAX = 9;
  localparam int unsigned BCD_W         = 4;
  localparam int unsigned NDIG_DEFAULT  = 3;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_CLR  = 2'd1,
    OP_UNDO = 2'd2,
    OP_ADD  = 2'd3
  } score_op_e;

endpackage

// File: rtl/bcd_digit_addsub.sv
// Single BCD digit adder/subtractor with carry/borrow chaining.
// Ports:
//   a_i   : current digit value (0..9)
//   b_i   : operand digit (0..9)
//   sub_i : 1 = a - b - c, 0 = a + b + c
//   c_i   : carry (add) or borrow (sub) from the lower digit
//   y_o   : result digit (0..9)
//   c_o   : carry or borrow into the next digit
module bcd_digit_addsub
  import scoreboard_pkg::*;
(
  input  logic [BCD_W-1:0] a_i,
  input  logic [BCD_W-1:0] b_i,
  input  logic             sub_i,
  input  logic             c_i,
  output logic [BCD_W-1:0] y_o,
  output logic             c_o
);

  localparam int unsigned RW   = BCD_W + 1;
  localparam int unsigned BASE = BCD_DIGIT_MAX + 1;

  logic [RW-1:0] raw;

  // Subtract range is -10..9, so the top bit of raw acts as the sign.
  always_comb begin
    raw = '0;
    y_o = a_i;
    c_o = 1'b0;
    if (sub_i) begin
      raw = RW'(a_i) - RW'(b_i) - RW'(c_i);
      if (raw[RW-1]) begin
        y_o = BCD_W'(raw + RW'(BASE));
        c_o = 1'b1;
      end else begin
        y_o = raw[BCD_W-1:0];
      end
    end else begin
      raw = RW'(a_i) + RW'(b_i) + RW'(c_i);
      if (raw > RW'(BCD_DIGIT_MAX)) begin
        y_o = BCD_W'(raw - RW'(BASE));
        c_o = 1'b1;
      end else begin
        y_o = raw[BCD_W-1:0];
      end
    end
  end

endmodule

// File: rtl/bcd_score_counter.sv
// Saturating BCD score counter with edge-detected +1/+2/+3/clear requests.
// Optional undo of the last addition when macro SCORE_UNDO_EN is defined;
// without it the undo port is accepted but ignored.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   add1, add2, add3  : level requests for +1/+2/+3 (rising edge = event)
//   clr               : level request to zero the score and overflow flag
//   undo              : level request to revert the last addition
//   bcd               : score, digit i in bits [4i+3:4i], digit 0 = units
//   upd               : one-cycle pulse when bcd changes (and on every clear)
//   ovf               : sticky saturation flag
module bcd_score_counter
  import scoreboard_pkg::*;
#(
  parameter int unsigned NDIG = NDIG_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                add1,
  input  logic                add2,
  input  logic                add3,
  input  logic                clr,
  input  logic                undo,
  output logic [4*NDIG-1:0]   bcd,
  output logic                upd,
  output logic                ovf
);

  localparam int unsigned SW = BCD_W * NDIG;
  localparam logic [SW-1:0] ALL_NINES = {NDIG{BCD_W'(BCD_DIGIT_MAX)}};

  logic [SW-1:0] bcd_q, bcd_d;
  logic          upd_q, upd_d;
  logic          ovf_q, ovf_d;
  logic [3:0]    req_prev_q;
  logic [3:0]    req, ev;
  logic          undo_ev;
  score_op_e     op;
  logic [1:0]    add_amt;
  logic [1:0]    operand;
  logic          sub;
  logic [SW-1:0] sum;
  logic [NDIG:0] carry;

  assign req = {clr, add3, add2, add1};
  assign ev  = req & ~req_prev_q;

`ifdef SCORE_UNDO_EN
  logic       undo_prev_q;
  logic [1:0] last_amt_q, last_amt_d;
  assign undo_ev = undo & ~undo_prev_q;
`else
  logic unused_undo;
  assign undo_ev     = 1'b0;
  assign unused_undo = undo;
`endif

  // Priority select: clr > undo > add3 > add2 > add1; losers are dropped.
  always_comb begin
    op      = OP_NONE;
    add_amt = 2'd0;
    if (ev[3]) begin
      op = OP_CLR;
    end else if (undo_ev) begin
      op = OP_UNDO;
    end else if (ev[2]) begin
      op      = OP_ADD;
      add_amt = 2'd3;
    end else if (ev[1]) begin
      op      = OP_ADD;
      add_amt = 2'd2;
    end else if (ev[0]) begin
      op      = OP_ADD;
      add_amt = 2'd1;
    end
  end

`ifdef SCORE_UNDO_EN
  assign sub     = (op == OP_UNDO);
  assign operand = sub ? last_amt_q : add_amt;
`else
  assign sub     = 1'b0;
  assign operand = add_amt;
`endif

  // Ripple chain: the operand only enters the units digit.
  assign carry[0] = 1'b0;
  for (genvar g = 0; g < NDIG; g++) begin : g_digit
    bcd_digit_addsub u_digit (
      .a_i   (bcd_q[g*BCD_W +: BCD_W]),
      .b_i   ((g == 0) ? BCD_W'(operand) : BCD_W'(0)),
      .sub_i (sub),
      .c_i   (carry[g]),
      .y_o   (sum[g*BCD_W +: BCD_W]),
      .c_o   (carry[g+1])
    );
  end

  // Next score, flags and stored undo amount.
  always_comb begin
    bcd_d = bcd_q;
    ovf_d = ovf_q;
`ifdef SCORE_UNDO_EN
    last_amt_d = last_amt_q;
`endif
    case (op)
      OP_CLR: begin
        bcd_d = '0;
        ovf_d = 1'b0;
`ifdef SCORE_UNDO_EN
        last_amt_d = 2'd0;
`endif
      end
      OP_UNDO: begin
        bcd_d = carry[NDIG] ? '0 : sum;
`ifdef SCORE_UNDO_EN
        last_amt_d = 2'd0;
`endif
      end
      OP_ADD: begin
        if (carry[NDIG]) begin
          bcd_d = ALL_NINES;
          ovf_d = 1'b1;
`ifdef SCORE_UNDO_EN
          // Overflow implies upper digits are all 9, so only units differ.
          last_amt_d = 2'(BCD_W'(BCD_DIGIT_MAX) - bcd_q[BCD_W-1:0]);
`endif
        end else begin
          bcd_d = sum;
`ifdef SCORE_UNDO_EN
          last_amt_d = add_amt;
`endif
        end
      end
      default: ;
    endcase
    upd_d = (op == OP_CLR) || (bcd_d != bcd_q);
  end

  // State registers; previous samples reset high to mask held requests.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bcd_q      <= '0;
      upd_q      <= 1'b0;
      ovf_q      <= 1'b0;
      req_prev_q <= '1;
`ifdef SCORE_UNDO_EN
      undo_prev_q <= 1'b1;
      last_amt_q  <= 2'd0;
`endif
    end else begin
      bcd_q      <= bcd_d;
      upd_q      <= upd_d;
      ovf_q      <= ovf_d;
      req_prev_q <= req;
`ifdef SCORE_UNDO_EN
      undo_prev_q <= undo;
      last_amt_q  <= last_amt_d;
`endif
    end
  end

  assign bcd = bcd_q;
  assign upd = upd_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_bcd_score_counter.sv
// Self-checking bench for bcd_score_counter (default NDIG=3).
// Honors SCORE_UNDO_EN the same way as the design.
module tb_bcd_score_counter;

  localparam logic [4:0] R_NONE = 5'b00000;
  localparam logic [4:0] R_ADD1 = 5'b00001;
  localparam logic [4:0] R_ADD2 = 5'b00010;
  localparam logic [4:0] R_ADD3 = 5'b00100;
  localparam logic [4:0] R_CLR  = 5'b01000;
  localparam logic [4:0] R_UNDO = 5'b10000;

  typedef struct {
    logic [4:0]  req;   // {undo, clr, add3, add2, add1}
    logic        rstn;
    logic [11:0] bcd;
    logic        upd;
    logic        ovf;
  } step_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        add1 = 1'b0, add2 = 1'b0, add3 = 1'b0, clr = 1'b0, undo = 1'b0;
  logic [11:0] bcd;
  logic        upd, ovf;

  step_t plan[$];
  step_t sb[$];
  int    tests = 0;
  int    fails = 0;

  bcd_score_counter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .add1  (add1),
    .add2  (add2),
    .add3  (add3),
    .clr   (clr),
    .undo  (undo),
    .bcd   (bcd),
    .upd   (upd),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic void plan_step(input logic [4:0] req, input logic rstn,
                                    input logic [11:0] b, input logic u, input logic o);
    step_t s;
    s.req = req; s.rstn = rstn; s.bcd = b; s.upd = u; s.ovf = o;
    plan.push_back(s);
  endfunction

  // Reach 'to' from 'from' with add pulses; expected score from integer math.
  function automatic void plan_climb(input int from, input int to, input logic o);
    int v = from;
    while (v < to) begin
      int amt = (to - v > 3) ? 3 : to - v;
      v += amt;
      plan_step(5'(1 << (amt - 1)), 1'b1, to_bcd(v), 1'b1, o);
      plan_step(R_NONE, 1'b1, to_bcd(v), 1'b0, o);
    end
  endfunction

  // Apply one cycle of stimulus and queue its expected result.
  task automatic drive(input step_t s);
    {undo, clr, add3, add2, add1} = s.req;
    rst_n = s.rstn;
    sb.push_back(s);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step_t e;
    plan.delete();
    plan_step(R_NONE, 1'b0, 12'h000, 1'b0, 1'b0);
    plan_step(R_NONE, 1'b0, 12'h000, 1'b0, 1'b0);
    plan_step(R_NONE, 1'b1, 12'h000, 1'b0, 1'b0);
    foreach (plan[k]) begin
      drive(plan[k]);
      e = sb.pop_front();
      tests++;
      if (bcd !== e.bcd || upd !== e.upd || ovf !== e.ovf) begin
        fails++;
        $display("FAIL reset[%0d]: got bcd=%h upd=%b ovf=%b, want bcd=%h upd=%b ovf=%b",
                 k, bcd, upd, ovf, e.bcd, e.upd, e.ovf);
      end
    end
  endtask

  task automatic test_add3_four();
    step_t e;
    plan.delete();
    plan_step(R_ADD3, 1'b1, 12'h003, 1'b1, 1'b0);
    plan_step(R_NONE, 1'b1, 12'h003, 1'b0, 1'b0);
    plan_step(R_ADD3, 1'b1, 12'h006, 1'b1, 1'b0);
    plan_step(R_NONE, 1'b1, 12'h006, 1'b0, 1'b0);
    plan_step(R_ADD3, 1'b1, 12'h009, 1'b1, 1'b0);
    plan_step(R_NONE, 1'b1, 12'h009, 1'b0, 1'b0);
    plan_step(R_ADD3, 1'b1, 12'h012, 1'b1, 1'b0);
    plan_step(R_NONE, 1'b1, 12'h012, 1'b0, 1'b0);
    foreach (plan[k]) begin
      drive(plan[k]);
      e = sb.pop_front();
      tests++;
      if (bcd !== e.bcd || upd !== e.upd || ovf !== e.ovf) begin
        fails++;
        $display("FAIL add3_four[%0d]: got bcd=%h upd=%b ovf=%b, want bcd=%h upd=%b ovf=%b",
                 k, bcd, upd, ovf, e.bcd, e.upd, e.ovf);
      end
    end
  endtask

  task automatic test_carry();
    step_t e;
    plan.delete();
    plan_step(R_CLR,  1'b1, 12'h000, 1'b1, 1'b0);
    plan_step(R_NONE, 1'b1, 12'h000, 1'b0, 1'b0);
    plan_climb(0, 98, 1'b0);
    plan_step(R_ADD3, 1'b1, 12'h101, 1'b1, 1'b0);
    plan_step(R_NONE, 1'b1, 12'h101, 1'b0, 1'b0);
    foreach (plan[k]) begin
      drive(plan[k]);
      e = sb.pop_front();
      tests++;
      if (bcd !== e.bcd || upd !== e.upd || ovf !== e.ovf) begin
        fails++;
        $display("FAIL carry[%0d]: got bcd=%h upd=%b ovf=%b, want bcd=%h upd=%b ovf=%b",
                 k, bcd, upd, ovf, e.bcd, e.upd, e.ovf);
      end
    end
  endtask

  task automatic test_saturation();
    step_t e;
    plan.delete();
    plan_step(R_CLR,  1'b1, 12'h000, 1'b1, 1'b0);
    plan_step(R_NONE, 1'b1, 12'h000, 1'b0, 1'b0);
    plan_climb(0, 998, 1'b0);
    plan_step(R_ADD3, 1'b1, 12'h999, 1'b1, 1'b1);
    plan_step(R_NONE, 1'b1, 12'h999, 1'b0, 1'b1);
`ifdef SCORE_UNDO_EN
    // Only +1 was actually applied, so undo returns to 998 with ovf kept.
    plan_step(R_UNDO, 1'b1, 12'h998, 1'b1, 1'b1);
    plan_step(R_NONE, 1'b1, 12'h998, 1'b0, 1'b1);
    plan_step(R_ADD3, 1'b1, 12'h999, 1'b1, 1'b1);
    plan_step(R_NONE, 1'b1, 12'h999, 1'b0, 1'b1);
`endif
    plan_step(R_ADD1, 1'b1, 12'h999, 1'b0, 1'b1);
    plan_step(R_NONE, 1'b1, 12'h999, 1'b0, 1'b1);
    // Applied increment was 0; undo has nothing to revert.
    plan_step(R_UNDO, 1'b1, 12'h999, 1'b0, 1'b1);
    plan_step(R_NONE, 1'b1, 12'h999, 1'b0, 1'b1);
    plan_step(R_CLR,  1'b1, 12'h000, 1'b1, 1'b0);
    plan_step(R_NONE, 1'b1, 12'h000, 1'b0, 1'b0);
    plan_step(R_CLR,  1'b1, 12'h000, 1'b1, 1'b0);
    plan_step(R_NONE, 1'b1, 12'h000, 1'b0, 1'b0);
    foreach (plan[k]) begin
      drive(plan[k]);
      e = sb.pop_front();
      tests++;
      if (bcd !== e.bcd || upd !== e.upd || ovf !== e.ovf) begin
        fails++;
        $display("FAIL saturation[%0d]: got bcd=%h upd=%b ovf=%b, want bcd=%h upd=%b ovf=%b",
                 k, bcd, upd, ovf, e.bcd, e.upd, e.ovf);
      end
    end
  endtask

  task automatic test_priority();
    step_t e;
    plan.delete();
    plan_step(R_CLR,  1'b1, 12'h000, 1'b1, 1'b0);
    plan_step(R_NONE, 1'b1, 12'h000, 1'b0, 1'b0);
    plan_climb(0, 5, 1'b0);
    plan_step(R_ADD2 | R_ADD1, 1'b1, 12'h007, 1'b1, 1'b0);
    plan_step(R_NONE, 1'b1, 12'h007, 1'b0, 1'b0);
    plan_step(R_ADD1, 1'b1, 12'h008, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) plan_step(R_ADD1, 1'b1, 12'h008, 1'b0, 1'b0);
    plan_step(R_NONE, 1'b1, 12'h008, 1'b0, 1'b0);
    plan_step(R_CLR | R_ADD3, 1'b1, 12'h000, 1'b1, 1'b0);
    plan_step(R_NONE, 1'b1, 12'h000, 1'b0, 1'b0);
    plan_step(R_ADD3 | R_ADD2, 1'b1, 12'h003, 1'b1, 1'b0);
    plan_step(R_NONE, 1'b1, 12'h003, 1'b0, 1'b0);
    foreach (plan[k]) begin
      drive(plan[k]);
      e = sb.pop_front();
      tests++;
      if (bcd !== e.bcd || upd !== e.upd || ovf !== e.ovf) begin
        fails++;
        $display("FAIL priority[%0d]: got bcd=%h upd=%b ovf=%b, want bcd=%h upd=%b ovf=%b",
                 k, bcd, upd, ovf, e.bcd, e.upd, e.ovf);
      end
    end
  endtask

  task automatic test_undo();
    step_t e;
    plan.delete();
    plan_step(R_CLR,  1'b1, 12'h000, 1'b1, 1'b0);
    plan_step(R_NONE, 1'b1, 12'h000, 1'b0, 1'b0);
    plan_climb(0, 10, 1'b0);
    plan_step(R_ADD3, 1'b1, 12'h013, 1'b1, 1'b0);
    plan_step(R_NONE, 1'b1, 12'h013, 1'b0, 1'b0);
`ifdef SCORE_UNDO_EN
    plan_step(R_UNDO, 1'b1, 12'h010, 1'b1, 1'b0);
    plan_step(R_NONE, 1'b1, 12'h010, 1'b0, 1'b0);
    plan_step(R_UNDO, 1'b1, 12'h010, 1'b0, 1'b0);
    plan_step(R_NONE, 1'b1, 12'h010, 1'b0, 1'b0);
    plan_step(R_ADD2, 1'b1, 12'h012, 1'b1, 1'b0);
    plan_step(R_NONE, 1'b1, 12'h012, 1'b0, 1'b0);
    plan_step(R_UNDO | R_ADD1, 1'b1, 12'h010, 1'b1, 1'b0);
    plan_step(R_NONE, 1'b1, 12'h010, 1'b0, 1'b0);
    plan_step(R_ADD3, 1'b1, 12'h013, 1'b1, 1'b0);
    plan_step(R_NONE, 1'b1, 12'h013, 1'b0, 1'b0);
    plan_step(R_CLR,  1'b1, 12'h000, 1'b1, 1'b0);
    plan_step(R_NONE, 1'b1, 12'h000, 1'b0, 1'b0);
    plan_step(R_ADD1, 1'b1, 12'h001, 1'b1, 1'b0);
    plan_step(R_NONE, 1'b1, 12'h001, 1'b0, 1'b0);
    plan_step(R_UNDO, 1'b1, 12'h000, 1'b1, 1'b0);
    plan_step(R_NONE, 1'b1, 12'h000, 1'b0, 1'b0);
`else
    plan_step(R_UNDO, 1'b1, 12'h013, 1'b0, 1'b0);
    plan_step(R_NONE, 1'b1, 12'h013, 1'b0, 1'b0);
    plan_step(R_UNDO, 1'b1, 12'h013, 1'b0, 1'b0);
    plan_step(R_NONE, 1'b1, 12'h013, 1'b0, 1'b0);
    plan_step(R_UNDO | R_ADD1, 1'b1, 12'h014, 1'b1, 1'b0);
    plan_step(R_NONE, 1'b1, 12'h014, 1'b0, 1'b0);
    plan_step(R_CLR,  1'b1, 12'h000, 1'b1, 1'b0);
    plan_step(R_NONE, 1'b1, 12'h000, 1'b0, 1'b0);
`endif
    plan_step(R_UNDO, 1'b1, 12'h000, 1'b0, 1'b0);
    plan_step(R_NONE, 1'b1, 12'h000, 1'b0, 1'b0);
    foreach (plan[k]) begin
      drive(plan[k]);
      e = sb.pop_front();
      tests++;
      if (bcd !== e.bcd || upd !== e.upd || ovf !== e.ovf) begin
        fails++;
        $display("FAIL undo[%0d]: got bcd=%h upd=%b ovf=%b, want bcd=%h upd=%b ovf=%b",
                 k, bcd, upd, ovf, e.bcd, e.upd, e.ovf);
      end
    end
  endtask

  task automatic test_reset_held();
    step_t e;
    plan.delete();
    plan_step(R_ADD2, 1'b1, 12'h002, 1'b1, 1'b0);
    plan_step(R_NONE, 1'b1, 12'h002, 1'b0, 1'b0);
    plan_step(R_ADD2, 1'b0, 12'h000, 1'b0, 1'b0);
    plan_step(R_ADD2, 1'b0, 12'h000, 1'b0, 1'b0);
    plan_step(R_ADD2, 1'b1, 12'h000, 1'b0, 1'b0);
    plan_step(R_ADD2, 1'b1, 12'h000, 1'b0, 1'b0);
    plan_step(R_ADD2, 1'b1, 12'h000, 1'b0, 1'b0);
    plan_step(R_NONE, 1'b1, 12'h000, 1'b0, 1'b0);
    plan_step(R_ADD2, 1'b1, 12'h002, 1'b1, 1'b0);
    plan_step(R_NONE, 1'b1, 12'h002, 1'b0, 1'b0);
    // Event coinciding with reset is lost.
    plan_step(R_ADD3, 1'b0, 12'h000, 1'b0, 1'b0);
    plan_step(R_NONE, 1'b1, 12'h000, 1'b0, 1'b0);
    plan_step(R_ADD1, 1'b1, 12'h001, 1'b1, 1'b0);
    plan_step(R_NONE, 1'b1, 12'h001, 1'b0, 1'b0);
    foreach (plan[k]) begin
      drive(plan[k]);
      e = sb.pop_front();
      tests++;
      if (bcd !== e.bcd || upd !== e.upd || ovf !== e.ovf) begin
        fails++;
        $display("FAIL reset_held[%0d]: got bcd=%h upd=%b ovf=%b, want bcd=%h upd=%b ovf=%b",
                 k, bcd, upd, ovf, e.bcd, e.upd, e.ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add3_four();
    test_carry();
    test_saturation();
    test_priority();
    test_undo();
    test_reset_held();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
